hw_accel_axil_slave_regs: RTL and testbench
===========================================

// Module: hw_accel_axil_slave_regs
// PURPOSE
//  AXI4-Lite responder (slave) register bank for the HW_Accelerator S00_AXI port; answers the
//  single-beat writes/reads the PS/VIP master issues. Holds NUM_REGS 32-bit R/W registers
//  (byte offsets 0x0,0x4,..), exposes them to accelerator datapath with one-cycle write pulses.
//  AW and W channels accepted independently; one write and one read outstanding at a time.
// PARAMETERS
//  DATA_W    32  data width; fixed at 32, WSTRB is DATA_W/8
//  ADDR_W    4   byte address width of S_AXI_AWADDR/S_AXI_ARADDR
//  NUM_REGS  4   number of implemented registers; offsets >= NUM_REGS*4 are unmapped
// PORTS
//  ACLK           in   1              clock; all logic rising-edge
//  ARESETN        in   1              asynchronous, active-low reset
//  S_AXI_AWADDR   in   ADDR_W         write address; bits[1:0] ignored
//  S_AXI_AWPROT   in   3              ignored
//  S_AXI_AWVALID  in   1 / S_AXI_AWREADY out 1   write-address handshake
//  S_AXI_WDATA    in   DATA_W         write data
//  S_AXI_WSTRB    in   DATA_W/8       byte enables
//  S_AXI_WVALID   in   1 / S_AXI_WREADY  out 1   write-data handshake
//  S_AXI_BRESP    out  2              00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1 / S_AXI_BREADY  in  1   write-response handshake
//  S_AXI_ARADDR   in   ADDR_W         read address; bits[1:0] ignored
//  S_AXI_ARPROT   in   3              ignored
//  S_AXI_ARVALID  in   1 / S_AXI_ARREADY out 1   read-address handshake
//  S_AXI_RDATA    out  DATA_W         read data
//  S_AXI_RRESP    out  2              00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1 / S_AXI_RREADY  in  1   read-data handshake
//  reg_q          out  NUM_REGS*32    register contents, reg k at [32k+31:32k]
//  reg_wr_pulse   out  NUM_REGS       1-cycle pulse when reg k committed (any strobe)
// BEHAVIOUR
//  Reset (ARESETN=0, async): all registers 0; AWREADY/WREADY/ARREADY/BVALID/RVALID 0 while
//   low; BRESP/RRESP 00; RDATA 0; reg_wr_pulse 0; held AW/W/AR captures discarded.
//   Reset mid-transaction: in-flight handshakes abandoned, no partial write, no response.
//  Write path (states W_COLLECT, W_RESP):
//   W_COLLECT: AWREADY = !aw_held; WREADY = !w_held. Handshake at edge E captures
//    addr/data/strb into holding regs (aw_held/w_held set). AW and W may arrive same cycle
//    or in either order, any gap.
//   Commit at edge following first cycle with aw_held&w_held: mapped -> bytes with WSTRB=1
//    updated, reg_wr_pulse[k]=1 for exactly that cycle, BRESP=00; unmapped -> no register
//    change, no pulse, BRESP=10. BVALID rises same edge; state -> W_RESP, held flags clear.
//   W_RESP: AWREADY=WREADY=0; BVALID/BRESP stable until BREADY=1; BVALID drops at
//    BVALID&BREADY edge, -> W_COLLECT. WSTRB=0 on mapped reg: OKAY, pulse, no byte change.
//  Read path (independent of write path):
//   ARREADY = !RVALID. AR handshake at edge E: RDATA/RRESP registered at E, RVALID=1 from
//    E (1-cycle latency). Mapped -> reg value, RRESP=00; unmapped -> RDATA=0, RRESP=10.
//   RDATA/RRESP/RVALID held until RVALID&RREADY; RVALID drops that edge; next AR accepted
//    the cycle after (no back-to-back AR while RVALID high).
//   Read and write commit on same reg at same edge: read returns pre-write value.
//  Address decode: index = addr[ADDR_W-1:2]; mapped iff index < NUM_REGS.
//  AXI rules: VALID outputs never drop before handshake; READY outputs do not depend
//   combinationally on VALID inputs.
// TESTING
//  4 writes 0x1..0x4 to 0x0..0xC, WSTRB=F, then 4 reads -> RDATA 1,2,3,4, all BRESP/RRESP=00.
//  AWVALID at cycle 0, WVALID at cycle 3 (and reverse order) -> one commit, one pulse,
//   BVALID 1 cycle after W handshake, register = WDATA.
//  reg1=0xFFFFFFFF, write 0x0000AABB WSTRB=0011 -> read 0xFFFFAABB.
//  Write 0x12345678 to 0x10 and read 0x10 -> BRESP=10, RRESP=10, RDATA=0, regs unchanged.
//  BREADY low 5 cycles after commit -> BVALID held, AWREADY=WREADY=0, 2nd write waits.
//  ARESETN low while aw_held set / RVALID high -> all VALIDs 0, reg_q=0, no BVALID after.

Source files
------------

// File: rtl/hw_accel_axil_slave_regs_if.sv
// AXI4-Lite bus bundle for the accelerator register bank (S00_AXI).
// The master drives the VALIDs and payloads; the slave drives the READYs and responses.
interface hw_accel_axil_slave_regs_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic [2:0]        S_AXI_AWPROT;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [DATA_W-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0] S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic [2:0]        S_AXI_ARPROT;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [DATA_W-1:0] S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/hw_accel_axil_slave_regs.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit R/W registers with per-register write pulses.
// AW and W are captured independently; one write and one read may be outstanding at a time.
module hw_accel_axil_slave_regs #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  hw_accel_axil_slave_regs_if.slave    s_axi,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          reg_wr_pulse
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wr_state_e;

  // Write path state
  wr_state_e                          wr_state_q, wr_state_d;
  logic                               aw_held_q, aw_held_d;
  logic [IDX_W-1:0]                   aw_idx_q, aw_idx_d;
  logic                               w_held_q, w_held_d;
  logic [DATA_W-1:0]                  wdata_q, wdata_d;
  logic [STRB_W-1:0]                  wstrb_q, wstrb_d;
  logic                               awready_q, awready_d;
  logic                               wready_q, wready_d;
  logic                               bvalid_q, bvalid_d;
  logic [1:0]                         bresp_q, bresp_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
  logic [NUM_REGS-1:0]                pulse_q, pulse_d;

  // Read path state
  logic                               arready_q, arready_d;
  logic                               rvalid_q, rvalid_d;
  logic [DATA_W-1:0]                  rdata_q, rdata_d;
  logic [1:0]                         rresp_q, rresp_d;

  logic                               aw_hs, w_hs, ar_hs;
  logic                               wr_mapped, rd_mapped;
  logic [IDX_W-1:0]                   ar_idx;

  assign aw_hs     = s_axi.S_AXI_AWVALID & awready_q;
  assign w_hs      = s_axi.S_AXI_WVALID  & wready_q;
  assign ar_hs     = s_axi.S_AXI_ARVALID & arready_q;
  assign ar_idx    = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
  assign wr_mapped = 32'(aw_idx_q) < NUM_REGS;
  assign rd_mapped = 32'(ar_idx) < NUM_REGS;

  // Protection bits and the byte-lane part of addresses carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Write path: collect AW/W in any order, commit once both are held, then hold B until taken
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    pulse_d    = '0;

    unique case (wr_state_q)
      W_COLLECT: begin
        if (aw_held_q && w_held_q) begin
          if (wr_mapped) begin
            for (int k = 0; k < int'(NUM_REGS); k++) begin
              if (aw_idx_q == IDX_W'(k)) begin
                for (int b = 0; b < int'(STRB_W); b++) begin
                  if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                end
                pulse_d[k] = 1'b1;
              end
            end
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          bvalid_d   = 1'b1;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = s_axi.S_AXI_AWADDR[ADDR_W-1:2];
          end
          if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.S_AXI_WDATA;
            wstrb_d  = s_axi.S_AXI_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = W_COLLECT;
        end
      end
      default: wr_state_d = W_COLLECT;
    endcase

    // READYs come from next-state flops only, never from the VALID inputs of this cycle
    awready_d = (wr_state_d == W_COLLECT) && !aw_held_d;
    wready_d  = (wr_state_d == W_COLLECT) && !w_held_d;
  end

  // Read path: single outstanding read, data registered on the AR handshake edge
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = rd_mapped ? RESP_OKAY : RESP_SLVERR;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (rd_mapped && (ar_idx == IDX_W'(k))) rdata_d = regs_q[k];
      end
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    arready_d = !rvalid_d;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state_q <= W_COLLECT;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      regs_q     <= '0;
      pulse_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      regs_q     <= regs_d;
      pulse_q    <= pulse_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign reg_q               = regs_q;
  assign reg_wr_pulse        = pulse_q;
endmodule

// File: tb/tb_hw_accel_axil_slave_regs.sv
// Self-checking bench for hw_accel_axil_slave_regs: directed cases plus random traffic
// compared against an array model of the register file.
module tb_hw_accel_axil_slave_regs;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0]    reg_wr_pulse;

  hw_accel_axil_slave_regs_if #(.ADDR_W(ADDR_W), .DATA_W(32)) axi ();

  hw_accel_axil_slave_regs #(.DATA_W(32), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .ACLK        (clk),
    .ARESETN     (rst_n),
    .s_axi       (axi.slave),
    .reg_q       (reg_q),
    .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [NUM_REGS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < int'(NUM_REGS); k++)
      check($sformatf("%s_reg%0d", tag, k), reg_q[32*k +: 32], model[k]);
  endtask

  // Full write: AW and W offered after independent delays, B accepted after b_dly cycles
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    bit hs_aw, hs_w;
    int cyc = 0;
    int idx = int'(addr[ADDR_W-1:2]);
    logic [1:0] exp_resp;
    logic [NUM_REGS-1:0] exp_pulse = '0;
    if (idx < int'(NUM_REGS)) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      exp_resp = 2'b00;
      exp_pulse[idx] = 1'b1;
    end else begin
      exp_resp = 2'b10;
    end
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge clk);
      axi.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      axi.S_AXI_AWADDR  = addr;
      axi.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
      axi.S_AXI_WDATA   = data;
      axi.S_AXI_WSTRB   = strb;
      hs_aw = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      hs_w  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(posedge clk);
      if (hs_aw) aw_done = 1;
      if (hs_w)  w_done = 1;
      cyc++;
    end
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 32'(aw_done && w_done), 32'd1);
      return;
    end
    check("wr_bvalid_not_early", 32'(axi.S_AXI_BVALID), 32'd0);
    @(negedge clk);
    check("wr_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
    check("wr_bresp", 32'(axi.S_AXI_BRESP), 32'(exp_resp));
    check("wr_pulse", 32'(reg_wr_pulse), 32'(exp_pulse));
    check("wr_awready_in_resp", 32'(axi.S_AXI_AWREADY), 32'd0);
    check("wr_wready_in_resp", 32'(axi.S_AXI_WREADY), 32'd0);
    check_regs("wr_commit");
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("wr_bvalid_held", 32'(axi.S_AXI_BVALID), 32'd1);
      check("wr_bresp_held", 32'(axi.S_AXI_BRESP), 32'(exp_resp));
      check("wr_awready_wait", 32'(axi.S_AXI_AWREADY), 32'd0);
      check("wr_pulse_once", 32'(reg_wr_pulse), 32'd0);
    end
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    check("wr_bvalid_drop", 32'(axi.S_AXI_BVALID), 32'd0);
    check("wr_pulse_gone", 32'(reg_wr_pulse), 32'd0);
    check("wr_awready_back", 32'(axi.S_AXI_AWREADY), 32'd1);
  endtask

  // Full read with R accepted after r_dly cycles
  task automatic axi_read(input logic [ADDR_W-1:0] addr, input int r_dly);
    int cyc = 0;
    int idx = int'(addr[ADDR_W-1:2]);
    logic [31:0] exp_data = (idx < int'(NUM_REGS)) ? model[idx] : 32'd0;
    logic [1:0]  exp_resp = (idx < int'(NUM_REGS)) ? 2'b00 : 2'b10;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_ARADDR  = addr;
    while (!axi.S_AXI_ARREADY && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!axi.S_AXI_ARREADY) begin
      axi.S_AXI_ARVALID = 1'b0;
      check("rd_arready_timeout", 32'(axi.S_AXI_ARREADY), 32'd1);
      return;
    end
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    check("rd_rvalid", 32'(axi.S_AXI_RVALID), 32'd1);
    check("rd_rdata", axi.S_AXI_RDATA, exp_data);
    check("rd_rresp", 32'(axi.S_AXI_RRESP), 32'(exp_resp));
    check("rd_arready_busy", 32'(axi.S_AXI_ARREADY), 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check("rd_rvalid_held", 32'(axi.S_AXI_RVALID), 32'd1);
      check("rd_rdata_held", axi.S_AXI_RDATA, exp_data);
    end
    axi.S_AXI_RREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_RREADY = 1'b0;
    check("rd_rvalid_drop", 32'(axi.S_AXI_RVALID), 32'd0);
    check("rd_arready_back", 32'(axi.S_AXI_ARREADY), 32'd1);
  endtask

  initial begin
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA  = '0; axi.S_AXI_WSTRB  = '0; axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b0;
    for (int k = 0; k < int'(NUM_REGS); k++) model[k] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    check("rst_arready", 32'(axi.S_AXI_ARREADY), 32'd0);
    check("rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    check("rst_rdata", axi.S_AXI_RDATA, 32'd0);
    check_regs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_awready", 32'(axi.S_AXI_AWREADY), 32'd1);
    check("post_rst_wready", 32'(axi.S_AXI_WREADY), 32'd1);
    check("post_rst_arready", 32'(axi.S_AXI_ARREADY), 32'd1);

    // Basic fill and readback
    for (int k = 0; k < 4; k++) axi_write(5'(4*k), 32'(k + 1), 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) axi_read(5'(4*k), 0);

    // AW leading W by three cycles, then the reverse
    axi_write(5'h04, 32'hDEAD0001, 4'hF, 0, 3, 0);
    axi_write(5'h08, 32'hBEEF0002, 4'hF, 3, 0, 1);

    // Partial strobe merge
    axi_write(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(5'h04, 32'h0000AABB, 4'b0011, 1, 0, 0);
    axi_read(5'h04, 0);
    check("strb_merge_value", model[1], 32'hFFFFAABB);
    axi_write(5'h0C, 32'h55555555, 4'b0000, 0, 0, 0);

    // Unmapped offset with byte-lane bits set: SLVERR, no register change
    axi_write(5'h10, 32'h12345678, 4'hF, 0, 0, 0);
    axi_read(5'h10, 2);
    axi_read(5'h1F, 0);

    // Slow BREADY holds off a second write
    axi_write(5'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 5);
    axi_write(5'h00, 32'h5A5A5A5A, 4'hF, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, $urandom_range(0, 3));
    end

    // Reset with a read pending and an AW held
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_ARADDR  = 5'h00;
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_AWADDR  = 5'h04;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    check("pre_rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    check("mid_rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    check("mid_rst_awready", 32'(axi.S_AXI_AWREADY), 32'd0);
    for (int k = 0; k < int'(NUM_REGS); k++) model[k] = 32'd0;
    check_regs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_rst_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
      check("after_rst_rvalid", 32'(axi.S_AXI_RVALID), 32'd0);
    end
    // W alone must not pair with the AW discarded by reset
    axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_WDATA  = 32'hCAFE0001;
    axi.S_AXI_WSTRB  = 4'hF;
    @(negedge clk);
    axi.S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stale_aw_no_bvalid", 32'(axi.S_AXI_BVALID), 32'd0);
    end
    check_regs("stale_aw");
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_AWADDR  = 5'h08;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    check("late_aw_bvalid_early", 32'(axi.S_AXI_BVALID), 32'd0);
    @(negedge clk);
    model[2] = 32'hCAFE0001;
    check("late_aw_bvalid", 32'(axi.S_AXI_BVALID), 32'd1);
    check("late_aw_pulse", 32'(reg_wr_pulse), 32'b0100);
    check_regs("late_aw");
    axi.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    axi.S_AXI_BREADY = 1'b0;
    check("late_aw_bvalid_drop", 32'(axi.S_AXI_BVALID), 32'd0);
    axi_read(5'h08, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
